// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - ALU operation codes, RV32I opcodes and the issue payload type
package alu_pkg;

  localparam int DATA_W = 32;

  typedef enum logic [3:0] {
    ALU_AND = 4'b0000,
    ALU_OR  = 4'b0001,
    ALU_ADD = 4'b0010,
    ALU_XOR = 4'b0100,
    ALU_SUB = 4'b0110,
    ALU_EQ  = 4'b1000,
    ALU_NOP = 4'b1111
  } alu_op_t;

  localparam logic [6:0] OPC_RTYPE  = 7'b0110011;
  localparam logic [6:0] OPC_IALU   = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef struct packed {
    logic [DATA_W-1:0] src_a;
    logic [DATA_W-1:0] src_b;
    alu_op_t           operation;
    logic [4:0]        rd;
    logic              branch_neg;
    logic              illegal;
  } alu_payload_t;

  localparam alu_payload_t PAYLOAD_RESET = '{
    src_a: '0, src_b: '0, operation: ALU_NOP, rd: 5'd0, branch_neg: 1'b0, illegal: 1'b0
  };

  function automatic logic [DATA_W-1:0] sext12(input logic [11:0] imm);
    return {{(DATA_W-12){imm[11]}}, imm};
  endfunction

endpackage

// File: rtl/alu_op_decode.sv
// rtl/alu_op_decode.sv - combinational RV32I instruction to ALU payload decode
module alu_op_decode
  import alu_pkg::*;
(
  input  logic [31:0]       instr,
  input  logic [DATA_W-1:0] rs1_data,
  input  logic [DATA_W-1:0] rs2_data,
  output alu_payload_t      payload
);

  logic [6:0]        opcode;
  logic [2:0]        funct3;
  logic [6:0]        funct7;
  logic [DATA_W-1:0] imm_i;
  logic [DATA_W-1:0] imm_s;
  logic              unused_bits;

  assign opcode      = instr[6:0];
  assign funct3      = instr[14:12];
  assign funct7      = instr[31:25];
  assign imm_i       = sext12(instr[31:20]);
  assign imm_s       = sext12({instr[31:25], instr[11:7]});
  assign unused_bits = &{1'b0, instr[19:15]};

  logic              legal;
  logic              writes_rd;
  logic              neg;
  alu_op_t           op;
  logic [DATA_W-1:0] src_b;

  always_comb begin
    legal     = 1'b0;
    writes_rd = 1'b0;
    neg       = 1'b0;
    op        = ALU_NOP;
    src_b     = rs2_data;
    case (opcode)
      OPC_RTYPE: begin
        writes_rd = 1'b1;
        legal     = (funct7 == F7_BASE);
        case (funct3)
          3'b000: begin
            op    = (funct7 == F7_ALT) ? ALU_SUB : ALU_ADD;
            legal = (funct7 == F7_BASE) || (funct7 == F7_ALT);
          end
          3'b111:  op = ALU_AND;
          3'b110:  op = ALU_OR;
          3'b100:  op = ALU_XOR;
          default: legal = 1'b0;
        endcase
      end
      OPC_IALU: begin
        writes_rd = 1'b1;
        src_b     = imm_i;
        legal     = 1'b1;
        case (funct3)
          3'b000:  op = ALU_ADD;
          3'b111:  op = ALU_AND;
          3'b110:  op = ALU_OR;
          3'b100:  op = ALU_XOR;
          default: legal = 1'b0;
        endcase
      end
      OPC_LOAD: begin
        writes_rd = 1'b1;
        src_b     = imm_i;
        op        = ALU_ADD;
        legal     = (funct3 <= 3'b010);
      end
      OPC_STORE: begin
        src_b = imm_s;
        op    = ALU_ADD;
        legal = (funct3 <= 3'b010);
      end
      OPC_BRANCH: begin
        op    = ALU_EQ;
        neg   = funct3[0];
        legal = (funct3[2:1] == 2'b00);
      end
      default: legal = 1'b0;
    endcase
  end

  // Illegal encodings collapse to a NOP with zeroed operands so execute never sees stale data.
  always_comb begin
    payload         = PAYLOAD_RESET;
    payload.illegal = 1'b1;
    if (legal) begin
      payload.src_a      = rs1_data;
      payload.src_b      = src_b;
      payload.operation  = op;
      payload.rd         = writes_rd ? instr[11:7] : 5'd0;
      payload.branch_neg = neg;
      payload.illegal    = 1'b0;
    end
  end

endmodule

// File: rtl/alu_issue.sv
// rtl/alu_issue.sv - single-slot registered issue stage feeding the ALU
module alu_issue
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH    = 32,
  parameter int OPCODE_LENGTH = 4,
  parameter int CNT_WIDTH     = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [31:0]              instr,
  input  logic [DATA_WIDTH-1:0]    rs1_data,
  input  logic [DATA_WIDTH-1:0]    rs2_data,
  input  logic                     flush,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_WIDTH-1:0]    SrcA,
  output logic [DATA_WIDTH-1:0]    SrcB,
  output logic [OPCODE_LENGTH-1:0] Operation,
  output logic [4:0]               rd,
  output logic                     branch_neg,
  output logic                     illegal,
  output logic [CNT_WIDTH-1:0]     illegal_count
);

  alu_payload_t         dec_payload;
  alu_payload_t         slot_q, slot_d;
  logic                 valid_q, valid_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 load;

  alu_op_decode u_decode (
    .instr    (instr),
    .rs1_data (rs1_data),
    .rs2_data (rs2_data),
    .payload  (dec_payload)
  );

  assign in_ready = !valid_q || out_ready;
  assign load     = in_valid && in_ready && !flush;

  always_comb begin
    slot_d  = slot_q;
    valid_d = valid_q;
    cnt_d   = cnt_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (load) begin
      valid_d = 1'b1;
      slot_d  = dec_payload;
      if (dec_payload.illegal && (cnt_q != '1)) begin
        cnt_d = cnt_q + 1'b1;
      end
    end else if (out_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      slot_q  <= PAYLOAD_RESET;
      valid_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      slot_q  <= slot_d;
      valid_q <= valid_d;
      cnt_q   <= cnt_d;
    end
  end

  assign out_valid     = valid_q;
  assign SrcA          = slot_q.src_a;
  assign SrcB          = slot_q.src_b;
  assign Operation     = slot_q.operation;
  assign rd            = slot_q.rd;
  assign branch_neg    = slot_q.branch_neg;
  assign illegal       = slot_q.illegal;
  assign illegal_count = cnt_q;

endmodule

// File: doc/alu_issue.md
# alu_issue

Issue stage on the initiator side of the ALU's operand/operation interface. It accepts one RV32I instruction per handshake, together with its register-file operands. It decodes the ALU operation code and the operand pair, and holds the result in a single registered output slot that the execute stage consumes through valid/ready. Illegal or unsupported encodings are flagged and counted, never silently dropped.

## Interface
Parameters:
- DATA_WIDTH, 32, operand width.
- OPCODE_LENGTH, 4, ALU operation code width.
- CNT_WIDTH, 8, width of the illegal-instruction counter.

Ports:
- clk  in  1  single clock; all state on its rising edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- in_valid  in  1  instruction and operands valid.
- in_ready  out  1  stage can accept this cycle.
- instr  in  32  RV32I instruction word.
- rs1_data  in  DATA_WIDTH  value of rs1.
- rs2_data  in  DATA_WIDTH  value of rs2.
- flush  in  1  discard held entry (branch redirect).
- out_valid  out  1  held entry valid.
- out_ready  in  1  execute stage consumes the entry.
- SrcA  out  DATA_WIDTH  ALU operand A.
- SrcB  out  DATA_WIDTH  ALU operand B.
- Operation  out  OPCODE_LENGTH  ALU operation code.
- rd  out  5  destination register, instr[11:7].
- branch_neg  out  1  invert the Equal result (BNE).
- illegal  out  1  entry is an unsupported encoding.
- illegal_count  out  CNT_WIDTH  saturating count of accepted illegal entries.

## Operation
- ALU codes: AND 4'b0000, OR 4'b0001, ADD 4'b0010, XOR 4'b0100, SUB 4'b0110, EQ 4'b1000, NOP 4'b1111 (the ALU returns 0 for NOP).
- R-type, opcode 7'b0110011, SrcA=rs1, SrcB=rs2:
  - funct3 000 with funct7 0000000 → ADD; with funct7 0100000 → SUB.
  - funct3 111 → AND, 110 → OR, 100 → XOR; each requires funct7 0000000.
- I-ALU, opcode 7'b0010011, SrcB = sign-extended instr[31:20]: funct3 000 → ADD, 111 → AND, 110 → OR, 100 → XOR.
- Load, opcode 7'b0000011, funct3 000/001/010 → ADD; SrcB = sign-extended I immediate.
- Store, opcode 7'b0100011, funct3 000/001/010 → ADD; SrcB = sign-extended {instr[31:25], instr[11:7]}; rd=0.
- Branch, opcode 7'b1100011, SrcB=rs2, rd=0: funct3 000 → EQ with branch_neg=0; 001 → EQ with branch_neg=1.
- Any other encoding: illegal=1, Operation=NOP, SrcA=SrcB=0, rd=0, branch_neg=0.
- Sign extension replicates instr[31] up to DATA_WIDTH.
- in_ready = !out_valid || out_ready; it is combinational from out_ready.
- Load condition: in_valid && in_ready && !flush. On load, the slot captures the decoded payload and out_valid=1.
- Hold: when out_valid && !out_ready && !flush, the payload and out_valid stay stable.
- Drain: out_ready with no load sets out_valid to 0.
- Flush priority: flush forces out_valid=0 next cycle and suppresses any load in the same cycle. in_ready still reflects the formula, so the upstream must also drop its beat on flush.
- illegal_count increments once per loaded illegal entry and saturates at all-ones. Flush does not decrement it.

## Timing
- Latency: 1 cycle from the accepted beat to out_valid.
- Throughput: 1 instruction/cycle while out_ready=1.
- Reset values: out_valid=0, SrcA=0, SrcB=0, Operation=NOP, rd=0, branch_neg=0, illegal=0, illegal_count=0.
- Reset asserted mid-hold drops the entry with no completion.
- Payload outputs are registered and do not change while out_valid && !out_ready.
- Simultaneous drain and load (out_valid=1, out_ready=1, in_valid=1): the new entry replaces the old one with no bubble.

## Structure
- Package alu_pkg holds:
  - the ALU operation code constants (typedef enum logic [3:0] alu_op_t);
  - RV opcode localparams;
  - the decoded payload struct (SrcA, SrcB, Operation, rd, branch_neg, illegal).
- Sub-module alu_op_decode: purely combinational instruction → payload decode.
- alu_issue itself contains the register slot, the handshake logic and the counter.

## Test plan
- R-type ADD (instr 32'h002081B3, rs1=5, rs2=7) → next cycle: out_valid=1, Operation=0010, SrcA=5, SrcB=7, rd=3.
- SUB (funct7 0100000) and ADDI with imm 12'hFFF → Operation=0110; then Operation=0010 with SrcB=32'hFFFFFFFF.
- BNE (funct3 001) → Operation=1000, branch_neg=1, rd=0.
- Stall with out_ready=0 for 3 cycles:
  - payload stable, in_ready=0;
  - releasing out_ready with in_valid=1 gives back-to-back transfers with no bubble.
- flush together with in_valid=1 → out_valid=0 next cycle and the beat is not captured.
- Illegal flow:
  - 256 illegal beats → illegal_count=8'hFF and it stays there;
  - asynchronous reset mid-hold → all outputs return to reset values with no clock edge.
